// File: rtl/mc_pkg.sv
// Shared multicycle-datapath definitions: one-hot select constants, the
// EMPTY/FULL buffer state type, and the one-hot legality helper.
package mc_pkg;

  localparam logic [2:0] SEL_P0 = 3'b001;
  localparam logic [2:0] SEL_P1 = 3'b010;
  localparam logic [2:0] SEL_P2 = 3'b100;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } demux_state_t;

  function automatic logic is_onehot3(input logic [2:0] sel);
    return (sel == SEL_P0) || (sel == SEL_P1) || (sel == SEL_P2);
  endfunction

endpackage

// File: rtl/onehot3_check.sv
// Combinational legal/illegal decode of a 3-bit one-hot select; shared with
// the merge mux so both sides agree on what counts as a legal select.
module onehot3_check
  import mc_pkg::*;
(
  input  logic [2:0] i_select,
  output logic       o_legal
);

  assign o_legal = is_onehot3(i_select);

endmodule

// File: rtl/demux3_reg.sv
// Registered one-hot 1-to-3 demultiplexer with valid/ready on every port.
// Define DEMUX3_ILLEGAL_ERR_EN to enable the sticky illegal-select flag oError.
module demux3_reg
  import mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] iData,
  input  logic [2:0]            select,
  input  logic                  iValid,
  output logic                  oReady,
  output logic [DATA_WIDTH-1:0] oData0,
  output logic [DATA_WIDTH-1:0] oData1,
  output logic [DATA_WIDTH-1:0] oData2,
  output logic                  oValid0,
  output logic                  oValid1,
  output logic                  oValid2,
  input  logic                  iReady0,
  input  logic                  iReady1,
  input  logic                  iReady2,
  input  logic                  iErrClr,
  output logic                  oError
);

  demux_state_t          r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic [2:0]            r_dest;

  logic w_legal;
  logic w_drain;
  logic w_accept;

  onehot3_check u_check (
    .i_select (select),
    .o_legal  (w_legal)
  );

  // Only the ready of the held destination can drain the buffer.
  assign w_drain  = (r_state == FULL) && |(r_dest & {iReady2, iReady1, iReady0});
  assign oReady   = (r_state == EMPTY) || w_drain;
  assign w_accept = iValid && oReady;

  // An accept always frees the slot or refills it, so an illegal word simply
  // leaves the buffer empty; a stalled FULL buffer cannot accept at all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_dest  <= '0;
    end else if (w_accept && w_legal) begin
      r_state <= FULL;
      r_data  <= iData;
      r_dest  <= select;
    end else if (w_accept || w_drain) begin
      r_state <= EMPTY;
    end
  end

  assign oValid0 = (r_state == FULL) && r_dest[0];
  assign oValid1 = (r_state == FULL) && r_dest[1];
  assign oValid2 = (r_state == FULL) && r_dest[2];

  assign oData0 = oValid0 ? r_data : '0;
  assign oData1 = oValid1 ? r_data : '0;
  assign oData2 = oValid2 ? r_data : '0;

`ifdef DEMUX3_ILLEGAL_ERR_EN
  logic r_error;

  // A new illegal accept takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error <= 1'b0;
    end else if (w_accept && !w_legal) begin
      r_error <= 1'b1;
    end else if (iErrClr) begin
      r_error <= 1'b0;
    end
  end

  assign oError = r_error;
`else
  assign oError = iErrClr & 1'b0;
`endif

endmodule

// File: tb/tb_demux3_reg.sv
// Directed, scoreboard-checked bench for demux3_reg; follows the
// DEMUX3_ILLEGAL_ERR_EN setting of the build for the expected oError value.
module tb_demux3_reg;

  localparam int W = 32;

  typedef struct packed {
    logic [2:0]   dest;
    logic [W-1:0] data;
  } sbItem_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] iData;
  logic [2:0]   select;
  logic         iValid;
  logic         oReady;
  logic [W-1:0] oData0, oData1, oData2;
  logic         oValid0, oValid1, oValid2;
  logic         iReady0, iReady1, iReady2;
  logic         iErrClr;
  logic         oError;

  sbItem_t sbQueue[$];
  int      nAsserts = 0;
  int      nFails   = 0;
  logic    errExp;

  demux3_reg #(.DATA_WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iData   (iData),
    .select  (select),
    .iValid  (iValid),
    .oReady  (oReady),
    .oData0  (oData0),
    .oData1  (oData1),
    .oData2  (oData2),
    .oValid0 (oValid0),
    .oValid1 (oValid1),
    .oValid2 (oValid2),
    .iReady0 (iReady0),
    .iReady1 (iReady1),
    .iReady2 (iReady2),
    .iErrClr (iErrClr),
    .oError  (oError)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one producer word; legal selects are expected to reach a consumer.
  task automatic applyStimulus(input logic [W-1:0] data, input logic [2:0] sel);
    sbItem_t item;
    iValid = 1'b1;
    iData  = data;
    select = sel;
    if (sel == 3'b001 || sel == 3'b010 || sel == 3'b100) begin
      item.dest = sel;
      item.data = data;
      sbQueue.push_back(item);
    end
  endtask

  task automatic checkHead(input string tag, input bit pop);
    sbItem_t item;
    if (sbQueue.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      item = sbQueue[0];
      checkOutput({tag, "_valid"}, {29'd0, oValid2, oValid1, oValid0}, {29'd0, item.dest});
      checkOutput({tag, "_data0"}, oData0, item.dest[0] ? item.data : '0);
      checkOutput({tag, "_data1"}, oData1, item.dest[1] ? item.data : '0);
      checkOutput({tag, "_data2"}, oData2, item.dest[2] ? item.data : '0);
      if (pop) void'(sbQueue.pop_front());
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, {29'd0, oValid2, oValid1, oValid0}, 32'd0);
    checkOutput({tag, "_data0"}, oData0, 32'd0);
    checkOutput({tag, "_data1"}, oData1, 32'd0);
    checkOutput({tag, "_data2"}, oData2, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef DEMUX3_ILLEGAL_ERR_EN
    errExp = 1'b1;
`else
    errExp = 1'b0;
`endif
    rst_n   = 1'b0;
    iData   = '0;
    select  = '0;
    iValid  = 1'b0;
    iReady0 = 1'b0;
    iReady1 = 1'b0;
    iReady2 = 1'b0;
    iErrClr = 1'b0;
    step();
    step();
    checkOutput("rst_ready", {31'd0, oReady}, 32'd1);
    checkOutput("rst_error", {31'd0, oError}, 32'd0);
    checkIdle("rst");
    rst_n = 1'b1;
    step();
    checkIdle("idle");

    // Single word to port 1 with its consumer ready.
    iReady1 = 1'b1;
    applyStimulus(32'hDEADBEEF, 3'b010);
    step();
    iValid = 1'b0;
    checkHead("p1", 1'b1);
    step();
    checkIdle("p1_drained");
    iReady1 = 1'b0;

    // Backpressure on port 2; other readies must not drain it.
    applyStimulus(32'h1, 3'b100);
    step();
    iValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iReady0 = i[0];
      iReady1 = ~i[0];
      #1;
      checkOutput("bp_ready", {31'd0, oReady}, 32'd0);
      checkHead("bp_hold", 1'b0);
      step();
    end
    checkHead("bp_hold_end", 1'b0);
    iReady0 = 1'b0;
    iReady1 = 1'b0;
    iReady2 = 1'b1;
    #1;
    checkOutput("bp_release_ready", {31'd0, oReady}, 32'd1);
    step();
    sbQueue.pop_front();
    checkIdle("bp_drained");

    // Back-to-back stream, one word per cycle.
    iReady0 = 1'b1;
    iReady1 = 1'b1;
    iReady2 = 1'b1;
    applyStimulus(32'hA0, 3'b001);
    step();
    applyStimulus(32'hA1, 3'b010);
    checkOutput("st_ready0", {31'd0, oReady}, 32'd1);
    checkHead("st_a0", 1'b1);
    step();
    applyStimulus(32'hA2, 3'b100);
    checkOutput("st_ready1", {31'd0, oReady}, 32'd1);
    checkHead("st_a1", 1'b1);
    step();
    iValid = 1'b0;
    checkHead("st_a2", 1'b1);
    step();
    checkIdle("st_drained");

    // Illegal select is dropped; oError follows the build option.
    applyStimulus(32'h55, 3'b011);
    step();
    iValid = 1'b0;
    checkIdle("ill");
    checkOutput("ill_error", {31'd0, oError}, {31'd0, errExp});
    step();
    checkOutput("ill_sticky", {31'd0, oError}, {31'd0, errExp});
    iErrClr = 1'b1;
    step();
    iErrClr = 1'b0;
    checkOutput("ill_cleared", {31'd0, oError}, 32'd0);
    applyStimulus(32'h66, 3'b000);
    iErrClr = 1'b1;
    step();
    iValid  = 1'b0;
    iErrClr = 1'b0;
    checkOutput("ill_set_wins", {31'd0, oError}, {31'd0, errExp});
    checkIdle("ill_zero");
    iErrClr = 1'b1;
    step();
    iErrClr = 1'b0;

    // Reset while holding a word clears outputs without waiting for a clock.
    iReady0 = 1'b0;
    applyStimulus(32'h77, 3'b001);
    step();
    iValid = 1'b0;
    checkHead("rm_full", 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdle("rm_async");
    sbQueue.delete();
    step();
    rst_n = 1'b1;
    checkOutput("rm_ready", {31'd0, oReady}, 32'd1);
    checkOutput("rm_error", {31'd0, oError}, 32'd0);
    step();
    checkIdle("rm_no_stale");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/demux3_reg.md
# demux3_reg

Registered one-hot 1-to-3 demultiplexer with valid/ready handshaking on all ports. One producer (typically the ALU/memory result path of the multicycle datapath) delivers a data word with a one-hot destination select. The block buffers the word in a single pipeline register and presents it to exactly one of three consumers. It is the splitting counterpart of the one-hot 3-input merge mux: select encoding is identical (3'b001, 3'b010, 3'b100 address port 0, 1, 2).

## Interface
Parameters:
- DATA_WIDTH, 32, payload width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- iData  input  DATA_WIDTH  payload from the producer.
- select  input  3  one-hot destination; sampled with iData.
- iValid  input  1  producer has a word.
- oReady  output  1  block can accept this cycle.
- oData0/oData1/oData2  output  DATA_WIDTH each  per-destination payload.
- oValid0/oValid1/oValid2  output  1 each  per-destination valid.
- iReady0/iReady1/iReady2  input  1 each  per-destination ready.
- iErrClr  input  1  clears oError (synchronous).
- oError  output  1  sticky illegal-select flag.

## Operation
- Two states: EMPTY and FULL. Holding registers: data (DATA_WIDTH bits) and dest (3-bit one-hot).
- Accept: the block accepts when iValid && oReady. oReady = (state == EMPTY) || drain, where drain = FULL && iReady of the held dest.
- Legal accept (select is exactly one-hot): data <= iData, dest <= select, next state FULL.
- Illegal accept (select is 000 or has more than one bit set): the word is consumed and dropped, with no output valid. If the state was FULL without drain, it stays FULL; otherwise it goes to EMPTY. oError handling is described under Configuration.
- Outputs: oValidk = FULL && dest[k]. oDatak = data when oValidk is high, otherwise all zeros.
- Drain: FULL with iReady of the held dest high moves the state to EMPTY, unless a legal accept happens in the same cycle.
- Simultaneous drain and legal accept: the state stays FULL and data/dest are replaced. This gives a throughput of one word per cycle.
- iReady of non-selected destinations is ignored.
- Reset: state EMPTY, data 0, dest 000, oError 0. Any held word is discarded.

## Timing
- Latency: a word accepted at edge N is visible on oValidk/oDatak right after edge N.
- Reset values of outputs: oReady 1, all oValidk 0, all oDatak 0, oError 0.
- oReady depends combinationally on iReady0..2. It has no combinational dependence on iValid or select.
- oValidk and oDatak come straight from registers, with only zero-gating. No input-to-output combinational path exists on the data side.
- Once oValidk is asserted, it holds with stable oDatak until the handshake completes. There is no retraction.
- Reset asserted mid-transfer clears outputs immediately (asynchronously). Deassertion is synchronous to clk by the system reset controller.

## Configuration
- Macro DEMUX3_ILLEGAL_ERR_EN.
- Defined: oError sets on any illegal-select accept and holds until iErrClr. If iErrClr and a new illegal accept occur in the same cycle, set wins.
- Undefined: oError is tied to 0 and iErrClr is ignored. Illegal selects are still dropped silently.
- Handshake and data behaviour are otherwise identical in both builds.

## Structure
- Shared package mc_pkg:
  - select constants SEL_P0 = 3'b001, SEL_P1 = 3'b010, SEL_P2 = 3'b100;
  - state type demux_state_t {EMPTY, FULL};
  - function is_onehot3().
- One sub-module, onehot3_check: a purely combinational legal/illegal decode of select. The same check is reusable by the merge mux for assertions.
- The remaining logic (state register, holding registers, output gating) lives in demux3_reg.

## Test plan
- Reset then idle: oReady=1, oValid0..2=0, oData0..2=0, oError=0.
- Accept 32'hDEADBEEF with select=3'b010 while iReady1=1: the next cycle shows oValid1=1 and oData1=32'hDEADBEEF, with oData0=oData2=0. After the drain edge, oValid1=0.
- Backpressure: hold iReady2=0 after sending 32'h1 to port 2. oReady=0, oValid2 stays 1 and oData2 stays 32'h1 for 5 cycles, while iReady0/iReady1 toggles have no effect. Raising iReady2 drains in one edge.
- Streaming: back-to-back 32'hA0, 32'hA1, 32'hA2 to ports 0, 1, 2 with all iReady high gives one word per cycle on the matching port, in order, with no bubble.
- Illegal select 3'b011 with data 32'h55 (DEMUX3_ILLEGAL_ERR_EN defined): no oValid asserts and oError=1 the next cycle and sticky. iErrClr pulse clears it. In the build without the macro, oError stays 0.
- Assert rst_n low while FULL holding 32'h77 for port 0: oValid0 drops to 0 immediately. After release, oReady=1 and no stale word appears.
